ap3_fifo_rd: RTL and testbench
==============================

# ap3_fifo_rd

Read-side controller for the AP3 `RAM` primitive when it runs in FIFO mode (`FMODE=1`). It watches the FIFO flags and drives `REN`. It absorbs the one-cycle registered `RDATA` latency in a 2-entry skid buffer and presents the data as a valid/ready stream to fabric logic. It sits between the `RAM` read port and any downstream consumer; the write side is untouched.

## Interface
Parameters:
- `DATA_WIDTH`, 32, width of `RDATA` and the stream data; 1..32.

Ports:
- `clk`  in  1  clock; also drives the RAM `RCLK`.
- `rst_n`  in  1  asynchronous, active-low reset.
- `fflush`  in  1  synchronous flush request from fabric.
- `ram_fflags`  in  4  RAM `FFLAGS`:
  - bit0 = empty (level == 0).
  - bit1 = almost-empty (level <= 1).
  - bits 3:2 unused.
- `ram_rdata`  in  DATA_WIDTH  RAM `RDATA`.
- `ram_ren`  out  1  RAM `REN`.
- `ram_fflush`  out  1  RAM `FFLUSH`.
- `m_valid`  out  1  stream data valid.
- `m_ready`  in  1  stream consumer ready.
- `m_data`  out  DATA_WIDTH  stream data.
- `level`  out  2  skid-buffer occupancy, 0..2.

## Operation
- RAM contract:
  - `ram_rdata` is valid exactly one cycle after a cycle with `ram_ren=1`; `ren_q` is the registered `ram_ren`.
  - Flags lag by one read: they reflect reads issued up to two cycles earlier, so they exclude the previous cycle's read.
- `pop = m_valid & m_ready`.
- `ram_ren = !empty & !fflush & !flush_q & !(ren_q & almost_empty) & (level + ren_q - pop < 2)`.
  - The almost-empty term prevents over-reading past the last word when the flag is stale.
  - The credit term guarantees the skid buffer never overflows.
- Skid buffer: 2-entry FIFO.
  - Push when `ren_q` (captures `ram_rdata`); pop on `pop`.
  - Push and pop in the same cycle keep `level` unchanged.
  - Head entry drives `m_data`; `m_valid = (level != 0)`.
- Stream rule: while `m_valid & !m_ready`, `m_data` is held stable.
- Flush, with `fflush` sampled high in cycle N:
  - `flush_q` is set for one cycle.
  - `ram_fflush` = `flush_q`, a one-cycle registered pulse per rising sample; repeated high cycles extend the pulse.
  - Skid buffer is cleared at the end of N.
  - Any `ren_q` data arriving in N or N+1 is discarded.
  - `ram_ren` = 0 in N and N+1.
- If `fflush` and `pop` occur in the same cycle, flush wins: the popped beat is considered delivered and the rest is discarded.
- Reset (async assert, sync release) forces:
  - `ram_ren`=0, `ram_fflush`=0, `m_valid`=0.
  - `m_data`=0, `level`=0, `ren_q`=0, `flush_q`=0.
  - Reset mid-stream drops all buffered and in-flight data.

## Timing
- First-word latency: `ram_ren` in cycle N → capture at the end of N+1 → `m_valid` in N+2.
- Sustained throughput is one word per cycle when the FIFO holds ≥2 words and `m_ready` is held high (steady state `level`=1, `ren_q`=1).
- Combinational paths:
  - `ram_fflags`, `m_ready`, `fflush` → `ram_ren`.
  - All other outputs are registered.
- Boundary behaviour:
  - With `m_ready`=0, at most 2 outstanding words (buffered plus in flight).
  - On an empty RAM, `ram_ren` never asserts.
  - With a single word, exactly one `ram_ren` pulse is issued.

## Structure
- Shared package `ap3_fifo_pkg`:
  - Flag bit indices `FFLAG_EMPTY=0`, `FFLAG_AEMPTY=1`.
  - `RAM_RD_LAT=1`.
  - `SKID_DEPTH=2`.
- One sub-module, `ap3_skid2`: the 2-entry data/occupancy buffer with push, pop, clear and `level`.
- Top level holds the REN credit logic, `ren_q` and flush sequencing.

## Test plan
- Reset: hold `rst_n`=0 with random inputs → `ram_ren`, `ram_fflush`, `m_valid`, `m_data`, `level` all 0; release gives no spurious `ram_ren` while empty.
- Burst: preload 0xA0..0xA3, `m_ready`=1:
  - `ram_ren` high for exactly 4 consecutive cycles (c0..c3).
  - `m_valid` in c2..c5 with `m_data` 0xA0, 0xA1, 0xA2, 0xA3.
  - No fifth read.
- Backpressure: preload 8 words, `m_ready`=0 → exactly 2 `ram_ren` pulses, `level`=2, `m_data`=first word held stable; then `m_ready`=1 → all 8 words in order, no loss or duplication.
- Single word: preload 0x55 → one `ram_ren`, one `m_valid` beat with 0x55, then `level`=0.
- Flush mid-stream: with `level`=2 and a read in flight, pulse `fflush` for 1 cycle:
  - Next cycle `m_valid`=0 and `level`=0.
  - `ram_fflush` high for exactly 1 cycle.
  - `ram_ren`=0 for 2 cycles; in-flight data never appears on `m_data`.
- Reset mid-stream: assert `rst_n`=0 while `level`=2 → outputs go to 0 immediately (async); after release with 3 new words preloaded, only the new words are delivered.

Source files
------------

// File: rtl/ap3_fifo_pkg.sv
// ap3_fifo_pkg: shared constants and types for the AP3 RAM FIFO read path
package ap3_fifo_pkg;
    localparam int FFLAG_EMPTY  = 0;
    localparam int FFLAG_AEMPTY = 1;
    localparam int RAM_RD_LAT   = 1;
    localparam int SKID_DEPTH   = 2;
    typedef logic [1:0] lvl_t;
endpackage

// File: rtl/ap3_skid2.sv
// ap3_skid2: 2-entry skid buffer capturing registered RAM read data
module ap3_skid2
    import ap3_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output lvl_t                  level
);
    logic [DATA_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
    lvl_t lvl_q, lvl_d;
    logic wr, rd;
    always_comb begin
        rd = pop && lvl_q != 2'd0;
        wr = push && (lvl_q != lvl_t'(SKID_DEPTH) || rd);
        lvl_d = clr ? 2'd0 : lvl_q + lvl_t'(wr) - lvl_t'(rd);
        head_d = rd ? (lvl_q == 2'd2 ? tail_q : din) : (wr && lvl_q == 2'd0 ? din : head_q);
        tail_d = wr && (lvl_q - lvl_t'(rd)) == 2'd1 ? din : tail_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            lvl_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            lvl_q  <= lvl_d;
        end
    end
    assign dout  = head_q;
    assign level = lvl_q;
endmodule

// File: rtl/ap3_fifo_rd.sv
// ap3_fifo_rd: AP3 RAM FIFO-mode read controller presenting a valid/ready stream
module ap3_fifo_rd
    import ap3_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fflush,
    input  logic [3:0]            ram_fflags,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  ram_ren,
    output logic                  ram_fflush,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [1:0]            level
);
    logic [RAM_RD_LAT-1:0] ren_q, ren_d;
    logic flush_q, flush_d, pop, push;
    logic [2:0] credit;
    logic unused_flags;
    assign unused_flags = ^ram_fflags[3:2];
    always_comb begin
        pop = m_valid & m_ready;
        credit = {1'b0, level} + 3'(ren_q) - 3'(pop);
        // flags exclude the read still in flight, so almost-empty blocks a second read
        ram_ren = rst_n & !ram_fflags[FFLAG_EMPTY] & !fflush & !flush_q
                & !(ren_q[0] & ram_fflags[FFLAG_AEMPTY]) & (credit < 3'(SKID_DEPTH));
        push = ren_q[RAM_RD_LAT-1] & !fflush & !flush_q;
        ren_d = ram_ren;
        flush_d = fflush;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ren_q   <= '0;
            flush_q <= 1'b0;
        end else begin
            ren_q   <= ren_d;
            flush_q <= flush_d;
        end
    end
    ap3_skid2 #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (fflush),
        .push  (push),
        .pop   (pop),
        .din   (ram_rdata),
        .dout  (m_data),
        .level (level)
    );
    assign m_valid    = level != 2'd0;
    assign ram_fflush = flush_q;
endmodule

// File: tb/tb_ap3_fifo_rd.sv
// tb_ap3_fifo_rd: scoreboard bench with a lagging-flag RAM FIFO model
module tb_ap3_fifo_rd;
    logic clk = 0, rst_n = 0, fflush = 0, m_ready = 0;
    logic [3:0] ram_fflags;
    logic [31:0] ram_rdata = 0, m_data;
    logic ram_ren, ram_fflush, m_valid;
    logic [1:0] level;
    int checks = 0, failures = 0;
    logic [31:0] exp_q[$], ram_q[$], load_words[$];
    int fcnt = 0;
    logic load_req = 0, load_ack = 0;

    always #5 clk = ~clk;

    ap3_fifo_rd #(.DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fflush     (fflush),
        .ram_fflags (ram_fflags),
        .ram_rdata  (ram_rdata),
        .ram_ren    (ram_ren),
        .ram_fflush (ram_fflush),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .level      (level)
    );

    assign ram_fflags = {2'b00, fcnt <= 1, fcnt == 0};

    // RAM model: flags registered from the pre-read size lag by one read
    always @(posedge clk) begin
        if (!rst_n || ram_fflush) begin
            ram_q.delete();
            fcnt <= 0;
        end else begin
            fcnt <= ram_q.size();
            if (ram_ren && ram_q.size() > 0) ram_rdata <= ram_q.pop_front();
            if (load_req != load_ack) begin
                foreach (load_words[i]) ram_q.push_back(load_words[i]);
                fcnt <= ram_q.size();
                load_ack = load_req;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL beat: got %0h expected no beat", m_data);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (m_data !== e) begin
                    failures++;
                    $display("FAIL beat: got %0h expected %0h", m_data, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int n, input logic [31:0] base, input int nexp);
        load_words.delete();
        for (int i = 0; i < n; i++) load_words.push_back(base + i);
        for (int i = 0; i < nexp; i++) exp_q.push_back(base + i);
        load_req = ~load_req;
        cyc();
    endtask

    task automatic count(input int k, output int nr, output int nv);
        nr = 0;
        nv = 0;
        repeat (k) begin
            @(negedge clk);
            nr += int'(ram_ren);
            nv += int'(m_valid);
        end
    endtask

    initial begin
        int nr, nv;
        logic [7:0] rv, mv;
        for (int i = 0; i < 4; i++) begin
            cyc();
            fflush  = 1'($urandom_range(0, 1));
            m_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("reset_outputs", {ram_ren, ram_fflush, m_valid, level, m_data}, 0);
        end
        cyc();
        fflush = 0;
        m_ready = 1;
        rst_n = 1;
        count(5, nr, nv);
        check("idle_ren", nr, 0);
        check("idle_valid", nv, 0);

        cyc();
        preload(4, 32'hA0, 4);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rv[i] = ram_ren;
            mv[i] = m_valid;
        end
        check("burst_ren", rv, 8'h0F);
        check("burst_valid", mv, 8'h3C);
        check("burst_drained", exp_q.size(), 0);

        cyc();
        m_ready = 0;
        preload(8, 32'hB0, 8);
        count(6, nr, nv);
        check("bp_ren", nr, 2);
        check("bp_level", level, 2);
        check("bp_head", m_data, 32'hB0);
        count(3, nr, nv);
        check("bp_hold", m_data, 32'hB0);
        check("bp_no_ren", nr, 0);
        cyc();
        m_ready = 1;
        repeat (20) @(negedge clk);
        check("bp_drained", exp_q.size(), 0);
        check("bp_level_end", level, 0);

        cyc();
        preload(1, 32'h55, 1);
        count(6, nr, nv);
        check("single_ren", nr, 1);
        check("single_valid", nv, 1);
        check("single_level", level, 0);

        cyc();
        m_ready = 0;
        preload(8, 32'hC0, 1);
        repeat (4) @(negedge clk);
        check("fl_level_pre", level, 2);
        cyc();
        m_ready = 1;
        cyc();
        m_ready = 0;
        fflush = 1;
        @(negedge clk);
        check("fl_ren_n", ram_ren, 0);
        check("fl_fflush_n", ram_fflush, 0);
        cyc();
        fflush = 0;
        @(negedge clk);
        check("fl_valid_level", {m_valid, level}, 0);
        check("fl_fflush_n1", ram_fflush, 1);
        check("fl_ren_n1", ram_ren, 0);
        cyc();
        @(negedge clk);
        check("fl_fflush_n2", ram_fflush, 0);
        m_ready = 1;
        count(6, nr, nv);
        check("fl_after_ren", nr, 0);
        check("fl_after_valid", nv, 0);

        cyc();
        m_ready = 0;
        preload(8, 32'hD0, 0);
        repeat (4) @(negedge clk);
        check("rm_level_pre", level, 2);
        @(posedge clk);
        #3 rst_n = 0;
        #1;
        check("rm_outputs", {ram_ren, ram_fflush, m_valid, level, m_data}, 0);
        cyc();
        cyc();
        rst_n = 1;
        m_ready = 1;
        preload(3, 32'hE0, 3);
        count(10, nr, nv);
        check("rm_ren", nr, 3);
        check("rm_valid", nv, 3);

        check("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
